bcd_updown_counter: RTL

Parametrised, fully synchronous multi-digit BCD counter. It counts 0 up to a programmable BCD terminal value, or back down, one digit per nibble. It adds count enable, direction, synchronous clear, parallel load with validation, and cascade/wrap flags. It replaces fixed two-digit counters built from chained mod-10 stages in display, timer and stopwatch paths; all digits share the single system clock, with no derived clocks.

---
 rtl/bcd_updown_counter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with programmable terminal value.
// One BCD digit per nibble (nibble [3:0] is the ones digit). Supports
// synchronous clear, validated parallel load, count enable and direction,
// a combinational terminal-count output for cascading, and registered
// one-cycle wrap / load_err pulses. Single clock domain, no derived clocks.
module bcd_updown_counter #(
  parameter int                  DIGITS  = 2,
  parameter logic [4*DIGITS-1:0] TOP_BCD = 8'h99
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // True when every nibble of v is a legal decimal digit (0..9).
  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  localparam logic TOP_LEGAL = is_bcd(TOP_BCD);

  // Elaboration-time sanity check of the parameters; behaviour with an
  // illegal terminal value is undefined, so flag it loudly.
  generate
    if (!TOP_LEGAL || DIGITS < 1 || DIGITS > 8) begin : g_bad_params
      $error("bcd_updown_counter: DIGITS must be 1..8 and every TOP_BCD nibble 0..9");
    end
  endgenerate

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         carry;
  logic         borrow;
  logic         at_top;
  logic         at_zero;
  logic         load_ok;

  // BCD increment: carry ripples through every nibble sitting at 9.
  always_comb begin
    inc_val = count;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // BCD decrement: borrow ripples through every nibble sitting at 0.
  always_comb begin
    dec_val = count;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // Terminal detection, load validation and the cascade output. A binary
  // compare against TOP_BCD is fine because BCD ordering matches binary.
  always_comb begin
    at_top  = (count == TOP_BCD);
    at_zero = (count == '0);
    load_ok = is_bcd(load_val) && (load_val <= TOP_BCD);
    tc      = en & (up ? at_top : at_zero);
  end

  // Count register and status pulses; priority is clr, load, en, hold.
  // wrap and load_err default low so each pulse lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        if (load_ok) begin
          count <= load_val;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        if (up) begin
          if (at_top) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= inc_val;
          end
        end else begin
          if (at_zero) begin
            count <= TOP_BCD;
            wrap  <= 1'b1;
          end else begin
            count <= dec_val;
          end
        end
      end
    end
  end

endmodule
